// File: rtl/dense_l1_engine.sv
// Dense layer 1 sequencer + 32-lane MAC engine with saturated outputs.
// Optional ReLU on outputs when DENSE_L1_RELU_EN is defined.

module dense_l1_lane #(
  parameter int FRAC  = 16,
  parameter int ACC_W = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               mac_en,
  input  logic               load_y,
  input  logic signed [31:0] x,
  input  logic signed [31:0] w,
  output logic [31:0]        y
);
  logic signed [63:0]      prod;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc;
  logic [31:0]             sat;

  assign prod = 64'(x) * 64'(w);
  assign term = ACC_W'(prod >>> FRAC);

  // acc fits in 32 bits when all bits above bit 31 equal the sign
  always_comb begin
    sat = acc[31:0];
    if (!(acc[ACC_W-1:31] == '0 || acc[ACC_W-1:31] == '1))
      sat = acc[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`ifdef DENSE_L1_RELU_EN
    if (sat[31]) sat = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      y   <= '0;
    end else begin
      if (clr)         acc <= '0;
      else if (mac_en) acc <= acc + term;
      if (load_y)      y <= sat;
    end
  end
endmodule

module dense_l1_engine #(
  parameter int N_IN    = 64,
  parameter int FRAC    = 16,
  parameter int MEM_LAT = 1,
  parameter int ACC_W   = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        x_valid,
  input  logic [31:0] x_data,
  output logic        x_ready,
  output logic [7:0]  addr_base,
  input  logic [31:0] w_din [31:0],
  output logic        y_valid,
  output logic [31:0] y_data [31:0],
  input  logic        y_ready,
  output logic        busy
);
  localparam int NUM_LANES = 32;
  localparam int CNT_W     = $clog2(N_IN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              x_hs, last, clr, load_y;
  logic [MEM_LAT:0]  vld_pipe;
  logic [MEM_LAT:1]  vld_q;
  logic [31:0]       x_q [MEM_LAT:1];

  assign x_hs     = x_valid & x_ready;
  assign last     = (cnt == CNT_W'(N_IN - 1));
  assign vld_pipe = {vld_q, x_hs};
  assign busy     = (state != IDLE);
  assign y_valid  = (state == OUT);

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    load_y    = 1'b0;
    case (state)
      IDLE:  if (start) begin state_nxt = RUN; clr = 1'b1; end
      RUN:   if (x_hs && last) state_nxt = DRAIN;
      // last accumulate has landed once no delayed valid is in flight
      DRAIN: if (~|vld_pipe[MEM_LAT:1]) begin state_nxt = OUT; load_y = 1'b1; end
      OUT:   if (y_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_base <= '0;
      x_ready   <= 1'b0;
      vld_q     <= '0;
    end else begin
      state <= state_nxt;
      vld_q <= vld_pipe[MEM_LAT-1:0];
      if (clr) begin
        cnt       <= '0;
        addr_base <= '0;
        x_ready   <= 1'b1;
      end else if (x_hs) begin
        cnt       <= cnt + 1'b1;
        addr_base <= 8'({cnt + 1'b1, 1'b0});
        if (last) x_ready <= 1'b0;
      end
    end
  end

  // activation delay line lines x up with the weight read MEM_LAT cycles later
  always_ff @(posedge clk) begin
    x_q[1] <= x_data;
    for (int s = 2; s <= MEM_LAT; s++) x_q[s] <= x_q[s-1];
  end

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    dense_l1_lane #(.FRAC(FRAC), .ACC_W(ACC_W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .mac_en (vld_pipe[MEM_LAT]),
      .load_y (load_y),
      .x      (x_q[MEM_LAT]),
      .w      (w_din[j]),
      .y      (y_data[j])
    );
  end
endmodule

// File: tb/tb_dense_l1_engine.sv
// Scoreboard bench for dense_l1_engine: banked weight-memory model, reference
// arithmetic model, decoupled output monitor.
module tb_dense_l1_engine;
  localparam int N     = 4;
  localparam int LAT   = 2;
  localparam int FRAC  = 16;
  localparam int ACC_W = 48;

  typedef logic [31:0][31:0] vec_t;

  logic        clk = 0, rst_n = 1, start = 0, x_valid = 0, y_ready = 1;
  logic [31:0] x_data = 0;
  logic        x_ready, y_valid, busy;
  logic [7:0]  addr_base;
  logic [31:0] w_din  [31:0];
  logic [31:0] y_data [31:0];
  logic [31:0] wpipe  [LAT][31:0];
  logic [31:0] mem    [16][256];
  logic signed [31:0] xv [N];
  logic signed [31:0] wv [32][N];
  vec_t exp_q[$];
  int total = 0, bad = 0, cyc = 0;

  dense_l1_engine #(.N_IN(N), .FRAC(FRAC), .MEM_LAT(LAT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_valid(x_valid), .x_data(x_data),
    .x_ready(x_ready), .addr_base(addr_base), .w_din(w_din), .y_valid(y_valid),
    .y_data(y_data), .y_ready(y_ready), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 16 banks: even word is neuron 2k, odd word neuron 2k+1; LAT-cycle read
  always @(posedge clk) begin
    for (int k = 0; k < 16; k++) begin
      wpipe[0][2*k]   <= mem[k][addr_base];
      wpipe[0][2*k+1] <= mem[k][addr_base | 8'd1];
    end
    for (int s = 1; s < LAT; s++) wpipe[s] <= wpipe[s-1];
  end
  assign w_din = wpipe[LAT-1];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
    int first;
    total++;
    if (act !== exp) begin
      bad++;
      first = 0;
      for (int j = 31; j >= 0; j--) if (act[j] !== exp[j]) first = j;
      $display("FAIL %s lane %0d: got %h want %h", name, first, act[first], exp[first]);
    end
  endtask

  task automatic fail(input string name);
    total++; bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic vec_t ycur();
    vec_t r;
    for (int j = 0; j < 32; j++) r[j] = y_data[j];
    return r;
  endfunction

  // Reference: per neuron, sum of floor(x*w / 2^FRAC), wrapped to ACC_W, saturated to 32 bits
  function automatic vec_t model();
    vec_t r;
    longint acc, a, b, p;
    longint maxv = 64'sd2147483647;
    longint minv = -64'sd2147483648;
    for (int j = 0; j < 32; j++) begin
      acc = 0;
      for (int i = 0; i < N; i++) begin
        a = xv[i]; b = wv[j][i];
        p = a * b;
        acc = acc + (p >>> FRAC);
        acc = (acc <<< (64 - ACC_W)) >>> (64 - ACC_W);
      end
      if (acc > maxv)      r[j] = 32'h7FFF_FFFF;
      else if (acc < minv) r[j] = 32'h8000_0000;
      else                 r[j] = acc[31:0];
`ifdef DENSE_L1_RELU_EN
      if (r[j][31]) r[j] = '0;
`endif
    end
    return r;
  endfunction

  // monitor: pops on every output handshake, checks hold while stalled
  initial begin
    vec_t held;
    bit   hold = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) hold = 0;
      else begin
        if (hold && y_valid) chk_vec("y_stall_hold", ycur(), held);
        if (y_valid && y_ready) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL y_unexpected: got %h want no output", y_data[0]);
          end else chk_vec("y_data", ycur(), exp_q.pop_front());
        end
        hold = y_valid && !y_ready;
        held = ycur();
      end
    end
  end

  // gap: 0 back-to-back, 1 pattern 1,0,0, 2 random
  task automatic run(input int gap, input int stall, input bit midstart,
                     input bit abort2, input bit chk_lat);
    int i, k, n, t0;
    bit hs;
    for (int kk = 0; kk < 16; kk++)
      for (int ii = 0; ii < N; ii++) begin
        mem[kk][2*ii]   = wv[2*kk][ii];
        mem[kk][2*ii+1] = wv[2*kk+1][ii];
      end
    if (!abort2) exp_q.push_back(model());
    y_ready = (stall == 0);
    start = 1; tick(); start = 0;
    t0 = cyc;
    chk("busy_after_start", 32'(busy), 1);
    chk("x_ready_after_start", 32'(x_ready), 1);
    i = 0; k = 0; n = 0;
    while (i < N && n < 200) begin
      x_valid = (gap == 0) ? 1'b1 : (gap == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      x_data  = xv[i];
      start   = midstart && (k == 2);
      hs      = x_valid && x_ready;
      if (hs) chk("addr_base", 32'(addr_base), 32'(2 * i));
      if (abort2 && i == 2) begin
        rst_n = 0; #1;
        chk_vec("y_data_on_reset", ycur(), '0);
        chk("y_valid_on_reset", 32'(y_valid), 0);
        chk("busy_on_reset", 32'(busy), 0);
        chk("x_ready_on_reset", 32'(x_ready), 0);
        chk("addr_on_reset", 32'(addr_base), 0);
        x_valid = 0; start = 0;
        tick(); rst_n = 1; tick();
        return;
      end
      tick();
      if (hs) i++;
      k++; n++;
    end
    x_valid = 0; start = 0;
    if (i < N) fail("x_accept_timeout");
    n = 0;
    while (!y_valid && n < 100) begin tick(); n++; end
    if (!y_valid) fail("y_valid_timeout");
    else if (chk_lat) chk("y_valid_latency", 32'(cyc), 32'(t0 + N + LAT + 1));
    repeat (stall) tick();
    y_ready = 1; tick();
    chk("y_valid_after_hs", 32'(y_valid), 0);
    chk("busy_after_hs", 32'(busy), 0);
  endtask

  task automatic set_w(input logic [31:0] v);
    for (int j = 0; j < 32; j++) for (int i = 0; i < N; i++) wv[j][i] = v;
  endtask

  task automatic set_x(input logic [31:0] v);
    for (int i = 0; i < N; i++) xv[i] = v;
  endtask

  task automatic set_case1();
    set_w(32'h0001_0000);
    for (int i = 0; i < N; i++) xv[i] = (i + 1) << 16;
  endtask

  initial begin
    logic signed [31:0] r;
    for (int k = 0; k < 16; k++) for (int a = 0; a < 256; a++) mem[k][a] = '0;
    #1 rst_n = 0;
    #1;
    chk("reset_x_ready", 32'(x_ready), 0);
    chk("reset_addr", 32'(addr_base), 0);
    chk("reset_y_valid", 32'(y_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk_vec("reset_y_data", ycur(), '0);
    tick(); tick(); rst_n = 1; tick();

    set_case1(); run(0, 0, 0, 0, 1);
    for (int j = 0; j < 32; j++) for (int i = 0; i < N; i++) wv[j][i] = (j + 1) << 16;
    set_x(32'h0000_8000); run(0, 0, 0, 0, 1);
    set_w(32'hFFFF_0000); set_x(32'h0001_0000); run(0, 0, 0, 0, 1);
    set_w(32'h4000_0000); set_x(32'h4000_0000); run(0, 0, 0, 0, 1);
    set_w(32'hC000_0000); run(0, 0, 0, 0, 1);
    set_w(32'h7FFF_FFFF); set_x(32'h7FFF_FFFF); run(0, 0, 0, 0, 1);
    set_w(32'h8000_0001); run(0, 1, 0, 0, 1);
    set_case1(); run(1, 5, 1, 0, 0);
    set_case1(); run(0, 0, 0, 1, 0);
    set_case1(); run(0, 0, 0, 0, 1);

    repeat (6) begin
      for (int i = 0; i < N; i++) begin
        r = $urandom; xv[i] = r >>> $urandom_range(0, 14);
      end
      for (int j = 0; j < 32; j++) for (int i = 0; i < N; i++) begin
        r = $urandom; wv[j][i] = r >>> $urandom_range(0, 14);
      end
      run(2, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 0);
    end

    repeat (5) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
